counter_step_ctrl: RTL and testbench

//  Upstream advance controller for the 4-bit lab counter. Turns two raw board buttons
//  (pause, step) into one single-cycle advance strobe `adv`. The counter is clocked by
//  clk and advances only when `adv` is high.
//  RUN: prescaler emits `adv` every DIV_MAX+1 cycles. PAUSE: one debounced step press

---
 rtl/counter_step_ctrl_if.sv | 36 +++
 rtl/counter_step_ctrl.sv | 153 +++++++++++++++
 tb/tb_counter_step_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/counter_step_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : counter_step_ctrl_if
// Description : Button inputs and advance/status outputs of the lab counter
//               advance controller, grouped as one bundle.
//   btn_pause  raw pause/run toggle button, active-high (master -> slave)
//   btn_step   raw single-step button, active-high      (master -> slave)
//   adv        one-cycle advance strobe                 (slave -> master)
//   running    1 in RUN, 0 in PAUSE/STEP                (slave -> master)
//   mode[1:0]  controller state: 00 RUN, 01 PAUSE, 10 STEP
// Revision    : 1.0 - initial release
// ============================================================================
interface counter_step_ctrl_if;
   logic       btn_pause;
   logic       btn_step;
   logic       adv;
   logic       running;
   logic [1:0] mode;

   modport master (
      output btn_pause,
      output btn_step,
      input  adv,
      input  running,
      input  mode
   );

   modport slave (
      input  btn_pause,
      input  btn_step,
      output adv,
      output running,
      output mode
   );
endinterface
`default_nettype wire

// File: rtl/counter_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : counter_step_ctrl
// Description : Advance controller for the 4-bit lab counter. Synchronizes and
//               debounces the pause and step buttons, runs a prescaler in RUN
//               mode, and emits a single-cycle advance strobe.
//   clk        system clock
//   rst        synchronous, active-high reset
//   bus        counter_step_ctrl_if.slave:
//                btn_pause, btn_step (raw, asynchronous inputs)
//                adv, running, mode  (registered outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module counter_step_ctrl #(
   parameter int DIV_W     = 20,
   parameter int DIV_MAX   = 999_999,
   parameter int DB_W      = 16,
   parameter int DB_CYCLES = 50_000
) (
   input  logic                  clk,
   input  logic                  rst,
   counter_step_ctrl_if.slave    bus
);

   localparam logic [DIV_W-1:0] c_div_max = DIV_W'(DIV_MAX);
   localparam logic [DB_W-1:0]  c_db_last = DB_W'(DB_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_PAUSE = 2'b01,
      ST_STEP  = 2'b10
   } state_t;

   // index 0 = pause button, index 1 = step button
   logic [1:0]       w_raw;
   logic [1:0]       w_press;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [DIV_W-1:0] r_div;
   logic             r_adv;
   logic             r_running;
   logic             w_adv_nxt;

   assign w_raw = {bus.btn_step, bus.btn_pause};

   // ------------------------------------------------------------------------
   // Per-button synchronizer, debouncer and rising-edge (press) detector.
   // A new level is accepted only after DB_CYCLES consecutive cycles in which
   // the synchronized input differs from the current debounced level.
   // ------------------------------------------------------------------------
   for (genvar i = 0; i < 2; i++) begin : g_btn
      logic            r_s1;
      logic            r_s2;
      logic            r_db;
      logic            r_db_d;
      logic [DB_W-1:0] r_cnt;

      always_ff @(posedge clk) begin
         if (rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_db   <= 1'b0;
            r_db_d <= 1'b0;
            r_cnt  <= '0;
         end else begin
            r_s1   <= w_raw[i];
            r_s2   <= r_s1;
            r_db_d <= r_db;
            if (r_s2 == r_db) begin
               r_cnt <= '0;
            end else if (r_cnt == c_db_last) begin
               // this edge would make the count reach DB_CYCLES
               r_db  <= ~r_db;
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end

      assign w_press[i] = r_db & ~r_db_d;
   end

   // ------------------------------------------------------------------------
   // Mode FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Mode FSM: next state and next advance strobe
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN: begin
            if (w_press[0]) w_state_nxt = ST_PAUSE;
         end
         ST_PAUSE: begin
            // pause wins; a step press on the same cycle is dropped
            if (w_press[0])      w_state_nxt = ST_RUN;
            else if (w_press[1]) w_state_nxt = ST_STEP;
         end
         ST_STEP: begin
            w_state_nxt = ST_PAUSE;
         end
         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase

      // The terminal-count term looks at the current state so that leaving
      // RUN on the terminal edge still delivers that period's advance. The
      // step term looks at the next state so adv coincides with STEP.
      w_adv_nxt = ((r_state == ST_RUN) && (r_div == c_div_max)) ||
                  (w_state_nxt == ST_STEP);
   end

   // ------------------------------------------------------------------------
   // Prescaler and registered outputs. The prescaler only advances while the
   // FSM stays in RUN, so it sits at 0 on the edge that enters RUN and the
   // first period after entry is a full DIV_MAX+1 cycles.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div     <= '0;
         r_adv     <= 1'b0;
         r_running <= 1'b1;
      end else begin
         if ((r_state != ST_RUN) || (w_state_nxt != ST_RUN)) begin
            r_div <= '0;
         end else if (r_div == c_div_max) begin
            r_div <= '0;
         end else begin
            r_div <= r_div + 1'b1;
         end
         r_adv     <= w_adv_nxt;
         r_running <= (w_state_nxt == ST_RUN);
      end
   end

   assign bus.adv     = r_adv;
   assign bus.running = r_running;
   assign bus.mode    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_counter_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_step_ctrl
// Description : Self-checking bench for counter_step_ctrl (DIV_MAX=9,
//               DB_CYCLES=4). Mode/running are checked against a stimulus
//               table and hand-written sequences; every adv cycle is checked
//               against a queue of expected advance edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_step_ctrl;

   localparam int DIV_MAX   = 9;
   localparam int DB_CYCLES = 4;
   localparam int PERIOD    = DIV_MAX + 1;

   logic clk;
   logic rst;
   int   edge_n;
   int   checks;
   int   errors;
   int   sb[$];

   counter_step_ctrl_if bus ();

   counter_step_ctrl #(
      .DIV_W     (4),
      .DIV_MAX   (DIV_MAX),
      .DB_W      (3),
      .DB_CYCLES (DB_CYCLES)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int         e;          // edge after which this row applies
      bit         rst;
      bit         pause;
      bit         step;
      logic [1:0] mode;       // expected mode after edge e
      bit         running;    // expected running after edge e
      int         adv_start;  // first expected adv edge pushed by this row
      int         adv_n;      // number of expected advs, PERIOD apart
   } vec_t;

   vec_t tbl[10];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", nm, edge_n, got, exp);
      end
   endtask

   // advance to 1 time unit after the given edge
   task automatic goto(input int e);
      while (edge_n < e) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_state(input logic [1:0] m, input bit r);
      chk("mode", int'(bus.mode), int'(m));
      chk("running", int'(bus.running), int'(r));
   endtask

   task automatic push_adv(input int start, input int n);
      for (int k = 0; k < n; k++) sb.push_back(start + PERIOD * k);
   endtask

   // adv scoreboard: every cycle adv must match the expected-edge queue
   always @(negedge clk) begin
      if (edge_n > 0) begin
         if (sb.size() > 0 && sb[0] == edge_n) begin
            void'(sb.pop_front());
            chk("adv_expected", int'(bus.adv), 1);
         end else begin
            chk("adv_idle", int'(bus.adv), 0);
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      edge_n        = 0;
      checks        = 0;
      errors        = 0;
      rst           = 1'b1;
      bus.btn_pause = 1'b0;
      bus.btn_step  = 1'b0;

      // reset release, RUN advances, pause entered on a terminal-count edge,
      // 50 quiet cycles in PAUSE, a clean single step
      tbl[0] = '{3,  0, 0, 0, 2'b00, 1, 13, 3};
      tbl[1] = '{26, 0, 1, 0, 2'b00, 1, 0,  0};
      tbl[2] = '{32, 0, 1, 0, 2'b00, 1, 0,  0};
      tbl[3] = '{33, 0, 1, 0, 2'b01, 0, 0,  0};
      tbl[4] = '{40, 0, 0, 0, 2'b01, 0, 0,  0};
      tbl[5] = '{83, 0, 0, 0, 2'b01, 0, 0,  0};
      tbl[6] = '{90, 0, 0, 1, 2'b01, 0, 0,  0};
      tbl[7] = '{96, 0, 0, 0, 2'b01, 0, 97, 1};
      tbl[8] = '{97, 0, 0, 0, 2'b10, 0, 0,  0};
      tbl[9] = '{98, 0, 0, 0, 2'b01, 0, 0,  0};

      for (int i = 0; i < 10; i++) begin
         goto(tbl[i].e);
         chk_state(tbl[i].mode, tbl[i].running);
         rst           = tbl[i].rst;
         bus.btn_pause = tbl[i].pause;
         bus.btn_step  = tbl[i].step;
         push_adv(tbl[i].adv_start, tbl[i].adv_n);
      end

      // bouncing step button: never stable long enough, no advance
      goto(100);
      chk_state(2'b01, 0);
      for (int k = 0; k < 20; k++) begin
         goto(110 + 2 * k);
         bus.btn_step = ((k % 2) == 0);
      end
      // then steady high: exactly one step
      goto(150);
      bus.btn_step = 1'b1;
      push_adv(157, 1);
      goto(156);
      chk_state(2'b01, 0);
      goto(157);
      chk_state(2'b10, 0);
      goto(158);
      chk_state(2'b01, 0);
      goto(170);
      bus.btn_step = 1'b0;

      // simultaneous pause and step in PAUSE: back to RUN, no step advance
      goto(190);
      bus.btn_pause = 1'b1;
      bus.btn_step  = 1'b1;
      push_adv(207, 2);
      goto(196);
      chk_state(2'b01, 0);
      goto(197);
      chk_state(2'b00, 1);
      goto(200);
      bus.btn_pause = 1'b0;
      bus.btn_step  = 1'b0;

      // one-cycle reset with a pause debounce count at 3 and prescaler mid-count
      goto(220);
      bus.btn_pause = 1'b1;
      goto(225);
      rst           = 1'b1;
      bus.btn_pause = 1'b0;
      goto(226);
      chk_state(2'b00, 1);
      rst = 1'b0;
      push_adv(236, 3);
      goto(233);
      chk_state(2'b00, 1);

      goto(260);
      chk("adv_pending", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
